floor_gray_sampler: RTL and testbench

- Upstream front end of the floor-position decode path.
- Samples the 3-bit Gray-coded floor sensor bus from the shaft, which is asynchronous and bouncy.
- Synchronizes and debounces the bus, then validates each committed change against the single-bit-step Gray property.
- Presents a stable Gray code to the Gray-to-binary decoder, plus a one-cycle floor-change strobe and a step-error flag for the elevator controller FSM.

---
 rtl/floor_gray_sampler_pkg.sv | 41 ++++
 rtl/floor_gray_sampler_sync_2ff.sv | 24 ++
 rtl/floor_gray_sampler.sv | 141 ++++++++++++++
 tb/tb_floor_gray_sampler.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/floor_gray_sampler_pkg.sv
// Shared types and helpers for the floor Gray-code sampling path.
// FLOOR_DIR_EN builds the direction outputs; gray_step_up serves that option.
package floor_pkg;

    localparam int GRAY_W = 3;

    typedef enum logic [1:0] {
        INIT   = 2'd0,
        STABLE = 2'd1,
        CAND   = 2'd2
    } state_t;

    function automatic logic [1:0] popcount3(input logic [2:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

    // Reflected-Gray increment: even parity flips bit 0, odd parity flips the
    // bit left of the lowest set bit; the top code (MSB only) wraps via the MSB.
    function automatic logic gray_step_up(input logic [GRAY_W-1:0] old_code,
                                          input logic [GRAY_W-1:0] new_code);
        logic [GRAY_W-1:0] diff;
        logic [GRAY_W-1:0] tgt;
        logic              found;
        diff  = old_code ^ new_code;
        tgt   = '0;
        found = 1'b0;
        if (!(^old_code))
            return diff[0];
        for (int i = 0; i < GRAY_W; i++) begin
            if (!found && old_code[i]) begin
                found = 1'b1;
                if (i == GRAY_W - 1)
                    tgt[i] = 1'b1;
                else
                    tgt[i+1] = 1'b1;
            end
        end
        return |(diff & tgt);
    endfunction

endpackage

// File: rtl/floor_gray_sampler_sync_2ff.sv
// Two-flop synchronizer for a multi-bit asynchronous bus; the debouncer
// downstream absorbs any skew between bits.
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/floor_gray_sampler.sv
// Synchronize, debounce and step-check the shaft Gray sensor bus.
// Define FLOOR_DIR_EN to add the dir_up/dir_down outputs.
module floor_gray_sampler
    import floor_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [GRAY_W-1:0] gray_raw,
    output logic [GRAY_W-1:0] gray_out,
    output logic              gray_valid,
    output logic              floor_change,
    output logic              step_err
`ifdef FLOOR_DIR_EN
    ,
    output logic              dir_up,
    output logic              dir_down
`endif
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam bit               SINGLE   = (DEBOUNCE_CYCLES == 1);

    logic [GRAY_W-1:0] gray_sync;
    logic [GRAY_W-1:0] cand;
    logic [GRAY_W-1:0] new_code;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_inc;
    logic              commit_step;
    logic              step_bad;
    state_t            state;

    sync_2ff #(.W(GRAY_W)) u_sync (
        .clk   (clk),
        .rst_n (reset_n),
        .d     (gray_raw),
        .q     (gray_sync)
    );

    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

    // Post-INIT commit decode, shared by the pulse logic and the direction option.
    always_comb begin
        commit_step = 1'b0;
        new_code    = cand;
        if (state == STABLE && SINGLE && gray_sync != gray_out) begin
            commit_step = 1'b1;
            new_code    = gray_sync;
        end
        if (state == CAND && gray_sync != gray_out && gray_sync == cand && cnt >= CNT_LAST)
            commit_step = 1'b1;
        step_bad = (popcount3(new_code ^ gray_out) != 2'd1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= INIT;
            cand         <= '0;
            cnt          <= '0;
            gray_out     <= '0;
            gray_valid   <= 1'b0;
            floor_change <= 1'b0;
            step_err     <= 1'b0;
        end else begin
            floor_change <= commit_step;
            step_err     <= commit_step & step_bad;
            case (state)
                INIT: begin
                    if (gray_sync == cand) begin
                        if (cnt >= CNT_LAST) begin
                            gray_out   <= cand;
                            gray_valid <= 1'b1;
                            cnt        <= '0;
                            state      <= STABLE;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end else if (SINGLE) begin
                        cand       <= gray_sync;
                        gray_out   <= gray_sync;
                        gray_valid <= 1'b1;
                        cnt        <= '0;
                        state      <= STABLE;
                    end else begin
                        cand <= gray_sync;
                        cnt  <= CNT_ONE;
                    end
                end
                STABLE: begin
                    if (gray_sync != gray_out) begin
                        cand <= gray_sync;
                        if (SINGLE) begin
                            gray_out <= gray_sync;
                        end else begin
                            cnt   <= CNT_ONE;
                            state <= CAND;
                        end
                    end
                end
                CAND: begin
                    if (gray_sync == gray_out) begin
                        cnt   <= '0;
                        state <= STABLE;
                    end else if (gray_sync != cand) begin
                        cand <= gray_sync;
                        cnt  <= CNT_ONE;
                    end else if (cnt >= CNT_LAST) begin
                        gray_out <= cand;
                        cnt      <= '0;
                        state    <= STABLE;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

`ifdef FLOOR_DIR_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dir_up   <= 1'b0;
            dir_down <= 1'b0;
        end else if (commit_step) begin
            if (step_bad) begin
                dir_up   <= 1'b0;
                dir_down <= 1'b0;
            end else begin
                dir_up   <= gray_step_up(gray_out, new_code);
                dir_down <= !gray_step_up(gray_out, new_code);
            end
        end
    end
`endif

endmodule

// File: tb/tb_floor_gray_sampler.sv
// Directed bench for floor_gray_sampler with DEBOUNCE_CYCLES=4 (6-edge latency).
module tb_floor_gray_sampler;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [2:0] gray_raw;
    logic [2:0] gray_out;
    logic       gray_valid;
    logic       floor_change;
    logic       step_err;
`ifdef FLOOR_DIR_EN
    logic       dir_up;
    logic       dir_down;
`endif

    int compared   = 0;
    int mismatched = 0;
    logic fc_seen;

    floor_gray_sampler #(.DEBOUNCE_CYCLES(4)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .gray_raw     (gray_raw),
        .gray_out     (gray_out),
        .gray_valid   (gray_valid),
        .floor_change (floor_change),
        .step_err     (step_err)
`ifdef FLOOR_DIR_EN
        ,
        .dir_up       (dir_up),
        .dir_down     (dir_down)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        gray_raw = 3'b011;
        tick(3);
        chk("rst_out",   8'(gray_out), 8'h0);
        chk("rst_valid", 8'(gray_valid), 8'h0);
        chk("rst_fc",    8'(floor_change), 8'h0);
        chk("rst_se",    8'(step_err), 8'h0);

        // Initial commit of 011 on edge 6 after release.
        reset_n = 1'b1;
        tick(5);
        chk("init_e5_valid", 8'(gray_valid), 8'h0);
        tick(1);
        chk("init_e6_valid", 8'(gray_valid), 8'h1);
        chk("init_e6_out",   8'(gray_out), 8'h3);
        chk("init_e6_fc",    8'(floor_change), 8'h0);
        chk("init_e6_se",    8'(step_err), 8'h0);

        // 011 -> 010 (floor 2 -> 3).
        gray_raw = 3'b010;
        tick(5);
        chk("up_e5_out", 8'(gray_out), 8'h3);
        chk("up_e5_fc",  8'(floor_change), 8'h0);
        tick(1);
        chk("up_e6_out", 8'(gray_out), 8'h2);
        chk("up_e6_fc",  8'(floor_change), 8'h1);
        chk("up_e6_se",  8'(step_err), 8'h0);
`ifdef FLOOR_DIR_EN
        chk("up_dir_up",   8'(dir_up), 8'h1);
        chk("up_dir_down", 8'(dir_down), 8'h0);
`endif
        tick(1);
        chk("up_e7_fc", 8'(floor_change), 8'h0);

        // Two-cycle glitch to 110 then back: rejected.
        gray_raw = 3'b110;
        tick(2);
        gray_raw = 3'b010;
        fc_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            fc_seen = fc_seen | floor_change;
        end
        chk("glitch_out", 8'(gray_out), 8'h2);
        chk("glitch_fc",  8'(fc_seen), 8'h0);

        // 110 for two cycles then 111 held: candidate restarts, 2-bit jump.
        gray_raw = 3'b110;
        tick(2);
        gray_raw = 3'b111;
        tick(5);
        chk("jump_e7_out", 8'(gray_out), 8'h2);
        chk("jump_e7_fc",  8'(floor_change), 8'h0);
        tick(1);
        chk("jump_e8_out", 8'(gray_out), 8'h7);
        chk("jump_e8_fc",  8'(floor_change), 8'h1);
        chk("jump_e8_se",  8'(step_err), 8'h1);
`ifdef FLOOR_DIR_EN
        chk("jump_dir", 8'({dir_up, dir_down}), 8'h0);
`endif
        tick(1);
        chk("jump_e9_fc", 8'(floor_change), 8'h0);
        chk("jump_e9_se", 8'(step_err), 8'h0);

        // Walk 111 -> 101 -> 100 (floors 5 -> 6 -> 7).
        gray_raw = 3'b101;
        tick(6);
        chk("w5_out", 8'(gray_out), 8'h5);
        chk("w5_se",  8'(step_err), 8'h0);
`ifdef FLOOR_DIR_EN
        chk("w5_dir_up", 8'(dir_up), 8'h1);
`endif
        gray_raw = 3'b100;
        tick(6);
        chk("w4_out", 8'(gray_out), 8'h4);
        chk("w4_fc",  8'(floor_change), 8'h1);

        // Wrap 100 -> 000 (floor 7 -> 0) is a legal up step.
        gray_raw = 3'b000;
        tick(5);
        chk("wrap_e5_out", 8'(gray_out), 8'h4);
        tick(1);
        chk("wrap_out", 8'(gray_out), 8'h0);
        chk("wrap_fc",  8'(floor_change), 8'h1);
        chk("wrap_se",  8'(step_err), 8'h0);
`ifdef FLOOR_DIR_EN
        chk("wrap_dir_up",   8'(dir_up), 8'h1);
        chk("wrap_dir_down", 8'(dir_down), 8'h0);
`endif

        // 000 -> 100 (floor 0 -> 7) is a legal down step.
        gray_raw = 3'b100;
        tick(6);
        chk("down_out", 8'(gray_out), 8'h4);
        chk("down_fc",  8'(floor_change), 8'h1);
        chk("down_se",  8'(step_err), 8'h0);
`ifdef FLOOR_DIR_EN
        chk("down_dir_up",   8'(dir_up), 8'h0);
        chk("down_dir_down", 8'(dir_down), 8'h1);
`endif

        // Reset while a candidate is pending.
        gray_raw = 3'b101;
        tick(4);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_out",   8'(gray_out), 8'h0);
        chk("mid_rst_valid", 8'(gray_valid), 8'h0);
        chk("mid_rst_fc",    8'(floor_change), 8'h0);
        chk("mid_rst_se",    8'(step_err), 8'h0);
`ifdef FLOOR_DIR_EN
        chk("mid_rst_dir", 8'({dir_up, dir_down}), 8'h0);
`endif
        gray_raw = 3'b011;
        tick(2);
        reset_n = 1'b1;
        fc_seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            fc_seen = fc_seen | floor_change;
        end
        chk("re_e5_valid", 8'(gray_valid), 8'h0);
        tick(1);
        fc_seen = fc_seen | floor_change;
        chk("re_e6_valid", 8'(gray_valid), 8'h1);
        chk("re_e6_out",   8'(gray_out), 8'h3);
        chk("re_fc",       8'(fc_seen), 8'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
